hc595_serializer: RTL and testbench
===================================

# hc595_serializer

Serial driver for the board's daisy-chained 74HC595 shift registers that carry the 7-segment display lines. It sits directly downstream of the hex/binary display scanner and consumes its packed `{segments, anodes}` word. It repeatedly snapshots the word, shifts it out MSB-first on DS/SHCP, and pulses STCP to transfer it to the register outputs. It also drives OE so the display stays blank until the first complete word has been latched.

## Interface
- `DATA_W`, default 12: width of the parallel word and number of bits shifted per frame; must be ≥ 1.
- `CLK_DIV`, default 4: clk cycles per SHCP/STCP half-period; must be ≥ 1.
- `clk` in 1: system clock. There is one clock domain and all logic is clocked on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_data` in DATA_W: parallel word to display. It is sampled only in the LOAD state.
- `o_stcp` out 1: storage-register latch clock (74HC595 ST_CP).
- `o_shcp` out 1: shift clock (74HC595 SH_CP).
- `o_ds` out 1: serial data (74HC595 DS).
- `o_oe` out 1: output enable, active-low (74HC595 OE#).
- `o_frame` out 1: single-cycle pulse asserted when a word has been latched.

## Operation
- **Reset** (while `rst_n` = 0, applied immediately and asynchronously):
  - `o_stcp` = 0, `o_shcp` = 0, `o_ds` = 0, `o_oe` = 1, `o_frame` = 0.
  - State = LOAD; shift register, bit counter and tick counter are cleared; the "latched once" flag is cleared.
- **State machine:** LOAD → SHIFT_LO → SHIFT_HI → (SHIFT_LO … | LATCH) → GAP → LOAD. The cycle runs continuously; there is no start input.
- **LOAD** (1 cycle):
  - `shreg <= i_data`, `o_ds <= i_data[DATA_W-1]`, `bit_cnt <= 0`, `tick <= 0`.
  - Next state: SHIFT_LO.
- **SHIFT_LO** (CLK_DIV cycles):
  - `o_shcp` = 0; `o_ds` is held stable.
  - When `tick == CLK_DIV-1`: `tick <= 0`, go to SHIFT_HI.
- **SHIFT_HI** (CLK_DIV cycles):
  - `o_shcp` = 1; `o_ds` is held stable. The 74HC595 samples DS on the SHCP rising edge.
  - At `tick == CLK_DIV-1`:
    - If `bit_cnt == DATA_W-1`, go to LATCH.
    - Otherwise shift `shreg` left by one, drive `o_ds` with the new MSB, increment `bit_cnt`, and go to SHIFT_LO.
- **LATCH** (CLK_DIV cycles):
  - `o_stcp` = 1, `o_shcp` = 0.
  - On exit, `o_frame` pulses for one cycle and the latched flag is set.
- **GAP** (CLK_DIV cycles): `o_stcp` = 0, `o_shcp` = 0; then go to LOAD.
- **OE rule:** `o_oe` = 1 until the first LATCH exits, then 0 permanently until the next reset.
- **Bit order:** `i_data[DATA_W-1]` is shifted first, `i_data[0]` last, so after latching `i_data[0]` sits in the first register stage.
- **Counter widths:** `bit_cnt` is `$clog2(DATA_W)` bits (minimum 1); `tick` is `$clog2(CLK_DIV)` bits (minimum 1). Neither counter wraps past its terminal value.
- **Boundary conditions:**
  - Changes on `i_data` outside the LOAD cycle are ignored until the next frame.
  - Reset mid-shift or mid-latch aborts the frame. Partial data already in the external 595 shift stage is never latched, because STCP stays 0.
  - With CLK_DIV = 1, SHCP toggles every cycle.
  - With DATA_W = 1, the frame consists of one bit followed by the latch.

## Timing
- **Frame period:** `T = 1 + 2·CLK_DIV·DATA_W + 2·CLK_DIV` clk cycles. With the defaults this is 1 + 96 + 8 = 105.
- **Relative to the LOAD cycle (cycle 0):**
  - Bit k's SHCP rising edge occurs at cycle `1 + CLK_DIV + 2·CLK_DIV·k`.
  - STCP rises at cycle `1 + 2·CLK_DIV·DATA_W`.
  - `o_frame` is high in the first cycle of GAP.
- **Setup/hold to the 595:** DS changes only at the SHIFT_HI→SHIFT_LO transition. This gives CLK_DIV cycles of setup and CLK_DIV cycles of hold around each SHCP rising edge.
- **Output type:** all outputs are registered; there are no combinational paths from `i_data`.
- **After reset release:** the first LOAD occurs on the first clk edge after `rst_n` rises.

## Test plan
- **Reset values:** hold `rst_n` = 0 for 5 cycles → STCP = 0, SHCP = 0, DS = 0, OE = 1, frame = 0. Assert `rst_n` low asynchronously mid-cycle → outputs reach these values without waiting for a clk edge.
- **Default frame, `i_data` = 12'hA5C:**
  - Sampling DS at each SHCP rising edge yields 1010_0101_1100.
  - STCP is high during cycles 97–100.
  - The frame pulse occurs at cycle 101; OE falls at the same time.
  - The next LOAD is at cycle 105.
- **Data change mid-frame:** change `i_data` from 12'hFFF to 12'h000 at cycle 40 → the current frame still shifts all ones; the next frame shifts all zeros.
- **Reset during shift:** assert reset at cycle 50 of frame 2 → STCP never pulses for that frame and OE returns to 1. After release, a full new frame completes and OE goes to 0 again.
- **Minimum divider, CLK_DIV = 1, DATA_W = 4, `i_data` = 4'b1001:**
  - SHCP toggles every cycle; DS sampled at rising edges is 1,0,0,1.
  - Frame period is 11 cycles; 20 consecutive frames are identical.
- **Continuous refresh:** run 1000 cycles with constant data → `o_frame` pulses exactly every T cycles and OE stays 0 after the first pulse.

Source files
------------

// File: rtl/hc595_serializer.sv
// Continuously refreshes a chain of 74HC595s: snapshot the word, shift it MSB-first on
// DS/SHCP, pulse STCP, idle for a gap, repeat. OE# is held high until the first word is latched.
module hc595_serializer #(
   parameter int DATA_W  = 12,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_stcp,
   output logic              o_shcp,
   output logic              o_ds,
   output logic              o_oe,
   output logic              o_frame
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      LATCH    = 3'd3,
      GAP      = 3'd4
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shifted;
   logic [BW-1:0]     bit_cnt;
   logic [TW-1:0]     tick;
   logic              latched;
   logic              tick_done;
   logic              last_bit;
   logic              shift_step;
   logic              frame_now;

   assign tick_done  = (tick == TICK_LAST);
   assign last_bit   = (bit_cnt == BIT_LAST);
   assign shifted    = shreg << 1;
   assign shift_step = (state == SHIFT_HI) && tick_done && !last_bit;
   assign frame_now  = (state == LATCH) && tick_done;

   always_comb begin
      state_n = state;
      case (state)
         LOAD:     state_n = SHIFT_LO;
         SHIFT_LO: if (tick_done) state_n = SHIFT_HI;
         SHIFT_HI: if (tick_done) state_n = last_bit ? LATCH : SHIFT_LO;
         LATCH:    if (tick_done) state_n = GAP;
         GAP:      if (tick_done) state_n = LOAD;
         default:  state_n = LOAD;
      endcase
   end

   // Pin outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOAD;
         shreg   <= '0;
         bit_cnt <= '0;
         tick    <= '0;
         latched <= 1'b0;
         o_stcp  <= 1'b0;
         o_shcp  <= 1'b0;
         o_ds    <= 1'b0;
         o_oe    <= 1'b1;
         o_frame <= 1'b0;
      end else begin
         state <= state_n;
         tick  <= (state == LOAD || tick_done) ? '0 : tick + 1'b1;
         if (state == LOAD) begin
            shreg   <= i_data;
            o_ds    <= i_data[DATA_W-1];
            bit_cnt <= '0;
         end else if (shift_step) begin
            shreg   <= shifted;
            o_ds    <= shifted[DATA_W-1];
            bit_cnt <= bit_cnt + 1'b1;
         end
         o_shcp  <= (state_n == SHIFT_HI);
         o_stcp  <= (state_n == LATCH);
         o_frame <= frame_now;
         if (frame_now) latched <= 1'b1;
         o_oe    <= ~(latched | frame_now);
      end
   end

endmodule

// File: tb/tb_hc595_serializer.sv
// Bench for hc595_serializer: two instances (default and CLK_DIV=1/DATA_W=4) checked against
// a frame-position waveform model and a scoreboard of words loaded at each frame start.
module tb_hc595_serializer;

   localparam int DW_A = 12;
   localparam int CD_A = 4;
   localparam int T_A  = 1 + 2*CD_A*DW_A + 2*CD_A;
   localparam int DW_B = 4;
   localparam int CD_B = 1;
   localparam int T_B  = 1 + 2*CD_B*DW_B + 2*CD_B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_a, rst_b;
   logic [DW_A-1:0] data_a;
   logic [DW_B-1:0] data_b;
   logic stcp_a, shcp_a, ds_a, oe_a, frame_a;
   logic stcp_b, shcp_b, ds_b, oe_b, frame_b;

   hc595_serializer #(.DATA_W(DW_A), .CLK_DIV(CD_A)) dut_a (
      .clk(clk), .rst_n(rst_a), .i_data(data_a),
      .o_stcp(stcp_a), .o_shcp(shcp_a), .o_ds(ds_a), .o_oe(oe_a), .o_frame(frame_a)
   );

   hc595_serializer #(.DATA_W(DW_B), .CLK_DIV(CD_B)) dut_b (
      .clk(clk), .rst_n(rst_b), .i_data(data_b),
      .o_stcp(stcp_b), .o_shcp(shcp_b), .o_ds(ds_b), .o_oe(oe_b), .o_frame(frame_b)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q0[$];
   logic [15:0] exp_q1[$];
   int          edges[2];
   logic [15:0] acc[2];
   int          nbits[2];
   logic        prev_shcp[2];
   logic        seen[2];
   int          frames[2];

   task automatic chk(input string name, input int ch, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ch%0d t=%0t actual=%h expected=%h", name, ch, $time, act, exp);
      end
   endtask

   // Reference timeline: frame k loads i_data at the k*T-th edge after reset release.
   always @(posedge clk) begin
      if (!rst_a) edges[0] = -1;
      else begin
         edges[0]++;
         if (edges[0] % T_A == 0) exp_q0.push_back(16'(data_a));
      end
      if (!rst_b) edges[1] = -1;
      else begin
         edges[1]++;
         if (edges[1] % T_B == 0) exp_q1.push_back(16'(data_b));
      end
   end

   task automatic mon(input int ch, input int dw, input int cd, input int t, input logic rst,
                      input logic stcp, input logic shcp, input logic ds, input logic oe,
                      input logic frame);
      int          pos;
      logic        e_shcp, e_stcp, e_frame;
      logic [15:0] w;
      logic [15:0] mask;
      mask = 16'((32'd1 << dw) - 1);
      if (!rst || edges[ch] < 0) begin
         chk("reset_vals", ch, {11'd0, stcp, shcp, ds, oe, frame}, 16'b00010);
         if (!rst) begin
            acc[ch] = '0; nbits[ch] = 0; prev_shcp[ch] = 1'b0; seen[ch] = 1'b0;
            if (ch == 0) exp_q0.delete(); else exp_q1.delete();
         end
         return;
      end
      pos     = (edges[ch] + 1) % t;
      e_shcp  = (pos >= 1) && (pos <= 2*cd*dw) && (((pos - 1) / cd) % 2 == 1);
      e_stcp  = (pos > 2*cd*dw) && (pos <= 2*cd*dw + cd);
      e_frame = (pos == 2*cd*dw + cd + 1);
      if (e_frame) seen[ch] = 1'b1;
      chk("shcp", ch, {15'd0, shcp}, {15'd0, e_shcp});
      chk("stcp", ch, {15'd0, stcp}, {15'd0, e_stcp});
      chk("frame", ch, {15'd0, frame}, {15'd0, e_frame});
      chk("oe", ch, {15'd0, oe}, {15'd0, ~seen[ch]});
      if (shcp && !prev_shcp[ch]) begin
         acc[ch] = {acc[ch][14:0], ds};
         nbits[ch]++;
      end
      prev_shcp[ch] = shcp;
      if (frame) begin
         frames[ch]++;
         if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
            chk("sb_empty", ch, 16'd1, 16'd0);
         end else begin
            w = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("sb_word", ch, acc[ch] & mask, w);
            chk("sb_nbits", ch, 16'(nbits[ch]), 16'(dw));
         end
         acc[ch] = '0;
         nbits[ch] = 0;
      end
   endtask

   always @(negedge clk) begin
      mon(0, DW_A, CD_A, T_A, rst_a, stcp_a, shcp_a, ds_a, oe_a, frame_a);
      mon(1, DW_B, CD_B, T_B, rst_b, stcp_b, shcp_b, ds_b, oe_b, frame_b);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         edges[i] = -1; acc[i] = '0; nbits[i] = 0; prev_shcp[i] = 1'b0; seen[i] = 1'b0; frames[i] = 0;
      end
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      data_a = 12'hA5C;
      data_b = 4'b1001;
      wait_cyc(5);
      rst_a = 1'b1;
      rst_b = 1'b1;
      wait_cyc(20);            // cycle 20 of frame 0: ignored until frame 1
      data_a = 12'hFFF;
      wait_cyc(125);           // cycle 145: frame 1 keeps shifting ones
      data_a = 12'h000;
      wait_cyc(105);           // cycle 250: loaded into frame 3
      data_a = 12'hFFF;
      wait_cyc(118);           // cycle 368 = frame 3 position 53, SHCP high, DS high, OE low
      rst_a = 1'b0;
      #1;
      chk("async_stcp", 0, {15'd0, stcp_a}, 16'd0);
      chk("async_shcp", 0, {15'd0, shcp_a}, 16'd0);
      chk("async_ds", 0, {15'd0, ds_a}, 16'd0);
      chk("async_oe", 0, {15'd0, oe_a}, 16'd1);
      chk("async_frame", 0, {15'd0, frame_a}, 16'd0);
      wait_cyc(3);
      rst_a = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         wait_cyc(1);
         if ($urandom_range(0, 29) == 0) data_a = DW_A'($urandom);
         if ($urandom_range(0, 7) == 0) data_b = DW_B'($urandom);
      end
      data_a = DW_A'($urandom);
      wait_cyc(1000);
      chk("frames_b_min", 1, 16'(frames[1] >= 20), 16'd1);
      chk("q0_backlog", 0, 16'(exp_q0.size() <= 1), 16'd1);
      chk("q1_backlog", 1, 16'(exp_q1.size() <= 1), 16'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
